epl_col_wr_ctrl: RTL

EPL_COL_WR_CTRL -- requirements
Module: epl_col_wr_ctrl

---
 rtl/epl_col_wr_ctrl_pkg.sv | 24 ++
 rtl/epl_col_wr_timer.sv | 33 +++
 rtl/epl_col_wr_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/epl_col_wr_ctrl_pkg.sv
// Shared widths, parameter defaults and FSM encoding for the column write
// controller and its phase timer.
package epl_col_wr_ctrl_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int TWORD_WIDTH = 8;
  localparam int ERRCNT_WIDTH = 8;
  localparam int TMR_WIDTH   = 4;
  localparam int RETRY_WIDTH = 3;

  localparam int DEF_PULSE_CYC = 3;
  localparam int DEF_RECOV_CYC = 1;
  localparam int DEF_MAX_RETRY = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_RECOV = 3'd3,
    ST_VRD   = 3'd4,
    ST_VCMP  = 3'd5
  } state_e;

endpackage

// File: rtl/epl_col_wr_timer.sv
// Load/decrement phase counter timing the PULSE and RECOV phases; zero_o
// flags the last cycle of the loaded phase.
module epl_col_wr_timer
  import epl_col_wr_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [TMR_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [TMR_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/epl_col_wr_ctrl.sv
// Column write controller: setup / pulse / recovery sequencing with optional
// read-back verify, bounded re-writes and a saturating failed-write count.
module epl_col_wr_ctrl
  import epl_col_wr_ctrl_pkg::*;
#(
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int RECOV_CYC = DEF_RECOV_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int VERIFY_EN = 1
) (
  input  logic                    pCLK_i,
  input  logic                    pRSTN_i,
  input  logic                    pWRITE_i,
  input  logic [ADDR_WIDTH-1:0]   pA_i,
  input  logic [TWORD_WIDTH-1:0]  pCODEWORD_i,
  output logic                    pRDY_o,
  output logic                    pCOL_WE_o,
  output logic                    pCOL_RE_o,
  output logic [ADDR_WIDTH-1:0]   pCOL_A_o,
  output logic [TWORD_WIDTH-1:0]  pCOL_D_o,
  input  logic [TWORD_WIDTH-1:0]  pCOL_Q_i,
  output logic                    pWrDone_o,
  output logic                    pWrErr_o,
  output logic [ERRCNT_WIDTH-1:0] pErrCnt_o
);

  localparam logic [TMR_WIDTH-1:0]   PULSE_LD = TMR_WIDTH'(PULSE_CYC - 1);
  localparam logic [TMR_WIDTH-1:0]   RECOV_LD = TMR_WIDTH'(RECOV_CYC - 1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_LIM = RETRY_WIDTH'(MAX_RETRY);

  state_e                  state_d, state_q;
  logic [ADDR_WIDTH-1:0]   hold_a_d, hold_a_q;
  logic [TWORD_WIDTH-1:0]  hold_d_d, hold_d_q;
  logic [RETRY_WIDTH-1:0]  retry_d, retry_q;
  logic [ERRCNT_WIDTH-1:0] err_cnt_d, err_cnt_q;
  logic [ADDR_WIDTH-1:0]   col_a_d, col_a_q;
  logic [TWORD_WIDTH-1:0]  col_d_d, col_d_q;
  logic rdy_d, rdy_q, we_d, we_q, re_d, re_q, done_d, done_q, err_d, err_q;

  logic                 tmr_load, tmr_dec, tmr_zero;
  logic [TMR_WIDTH-1:0] tmr_val;

  epl_col_wr_timer u_timer (
    .clk        (pCLK_i),
    .rst_n      (pRSTN_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    hold_a_d  = hold_a_q;
    hold_d_d  = hold_d_q;
    retry_d   = retry_q;
    err_cnt_d = err_cnt_q;
    col_a_d   = col_a_q;
    col_d_d   = col_d_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rdy_q && pWRITE_i) begin
          hold_a_d = pA_i;
          hold_d_d = pCODEWORD_i;
          retry_d  = '0;
          col_a_d  = pA_i;
          col_d_d  = pCODEWORD_i;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        col_a_d  = hold_a_q;
        col_d_d  = hold_d_q;
        we_d     = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = ST_PULSE;
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = RECOV_LD;
          state_d  = ST_RECOV;
        end else begin
          we_d    = 1'b1;
          tmr_dec = 1'b1;
        end
      end
      ST_RECOV: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (VERIFY_EN != 0) begin
          re_d    = 1'b1;
          state_d = ST_VRD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_VRD: state_d = ST_VCMP;
      ST_VCMP: begin
        // Compare against the held codeword exactly as written, corruption included.
        if (pCOL_Q_i == hold_d_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_SETUP;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  // NOTE: holding registers are plain flops, so they are reset with the rest
  // of the state and never show stale data after reset.
  always_ff @(posedge pCLK_i or negedge pRSTN_i) begin
    if (!pRSTN_i) begin
      state_q   <= ST_IDLE;
      hold_a_q  <= '0;
      hold_d_q  <= '0;
      retry_q   <= '0;
      err_cnt_q <= '0;
      col_a_q   <= '0;
      col_d_q   <= '0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_a_q  <= hold_a_d;
      hold_d_q  <= hold_d_d;
      retry_q   <= retry_d;
      err_cnt_q <= err_cnt_d;
      col_a_q   <= col_a_d;
      col_d_q   <= col_d_d;
      rdy_q     <= rdy_d;
      we_q      <= we_d;
      re_q      <= re_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pRDY_o    = rdy_q;
  assign pCOL_WE_o = we_q;
  assign pCOL_RE_o = re_q;
  assign pCOL_A_o  = col_a_q;
  assign pCOL_D_o  = col_d_q;
  assign pWrDone_o = done_q;
  assign pWrErr_o  = err_q;
  assign pErrCnt_o = err_cnt_q;

endmodule
